// File: rtl/am_uart_sched.sv
// Two-channel ADC byte scheduler: frames bursts of BURST_LEN bytes behind a per-channel header
// for one UART. Define SCHED_CHKSUM_EN to append an XOR checksum byte to every frame.
module am_uart_sched #(
    parameter int unsigned BURST_LEN = 16,
    parameter logic [7:0]  HDR0      = 8'hA5,
    parameter logic [7:0]  HDR1      = 8'h5A
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       en,
    input  logic [7:0] ch0_data,
    input  logic       ch0_valid,
    output logic       ch0_ready,
    input  logic [7:0] ch1_data,
    input  logic       ch1_valid,
    output logic       ch1_ready,
    input  logic       uart_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       grant_ch,
    output logic       frame_done,
    output logic       sched_busy
);

    localparam logic [7:0] BurstLen = 8'(BURST_LEN);

`ifdef SCHED_CHKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StHdr, StFetch, StSend, StCsum, StGuard, StWaitb, StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StHdr, StFetch, StSend, StGuard, StWaitb, StDone
    } state_e;
`endif

    state_e     state_q;
    logic [7:0] byte_cnt_q;
    logic       last_ch_q;
    logic [7:0] tx_data_q;
    logic       tx_start_q;
    logic       grant_q;
    logic       frame_done_q;
    logic       sched_busy_q;
`ifdef SCHED_CHKSUM_EN
    logic [7:0] csum_q;
    logic       csum_sent_q;
`endif

    logic       start_req;
    logic       start_grant;
    logic       in_fetch;
    logic       accept;
    logic [7:0] gnt_data;

    // On a tie the channel that did not own the previous frame wins.
    always_comb begin
        start_grant = (ch0_valid && ch1_valid) ? ~last_ch_q : ch1_valid;
        start_req   = en && !uart_busy && (ch0_valid || ch1_valid);
        in_fetch    = (state_q == StFetch);
        ch0_ready   = in_fetch && !grant_q;
        ch1_ready   = in_fetch && grant_q;
        gnt_data    = grant_q ? ch1_data : ch0_data;
        accept      = grant_q ? (ch1_valid && ch1_ready) : (ch0_valid && ch0_ready);
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q      <= StIdle;
            byte_cnt_q   <= '0;
            last_ch_q    <= 1'b1;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            grant_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sched_busy_q <= 1'b0;
`ifdef SCHED_CHKSUM_EN
            csum_q       <= '0;
            csum_sent_q  <= 1'b0;
`endif
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        grant_q      <= start_grant;
                        tx_data_q    <= start_grant ? HDR1 : HDR0;
                        tx_start_q   <= 1'b1;
                        sched_busy_q <= 1'b1;
                        state_q      <= StHdr;
                    end
                end
                StHdr: begin
`ifdef SCHED_CHKSUM_EN
                    csum_q      <= '0;
                    csum_sent_q <= 1'b0;
`endif
                    state_q <= StGuard;
                end
                StFetch: begin
                    if (accept) begin
                        tx_data_q  <= gnt_data;
                        tx_start_q <= 1'b1;
`ifdef SCHED_CHKSUM_EN
                        csum_q     <= csum_q ^ gnt_data;
`endif
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                    state_q    <= StGuard;
                end
`ifdef SCHED_CHKSUM_EN
                StCsum: begin
                    csum_sent_q <= 1'b1;
                    state_q     <= StGuard;
                end
`endif
                // The UART raises busy a cycle after the strobe, so this cycle cannot trust it.
                StGuard: state_q <= StWaitb;
                StWaitb: begin
                    if (!uart_busy) begin
                        if (byte_cnt_q < BurstLen) begin
                            state_q <= StFetch;
`ifdef SCHED_CHKSUM_EN
                        end else if (!csum_sent_q) begin
                            tx_data_q  <= csum_q;
                            tx_start_q <= 1'b1;
                            state_q    <= StCsum;
`endif
                        end else begin
                            frame_done_q <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StDone: begin
                    last_ch_q    <= grant_q;
                    byte_cnt_q   <= '0;
                    sched_busy_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign grant_ch   = grant_q;
    assign frame_done = frame_done_q;
    assign sched_busy = sched_busy_q;

    a_ready_onehot: assert property (@(posedge CLK) disable iff (!RST_n)
        !(ch0_ready && ch1_ready));
    a_start_pulse: assert property (@(posedge CLK) disable iff (!RST_n)
        tx_start_q |=> !tx_start_q);
    a_start_not_busy: assert property (@(posedge CLK) disable iff (!RST_n)
        tx_start_q |-> !uart_busy);

endmodule

// File: tb/tb_am_uart_sched.sv
// Bench for am_uart_sched: table-driven frame vectors, hand-written corner sequences and
// randomized traffic checked against a queue-level arbitration and framing model.
module tb_am_uart_sched;

    localparam int unsigned BL = 4;
    localparam logic [7:0]  H0 = 8'hA5;
    localparam logic [7:0]  H1 = 8'h5A;
`ifdef SCHED_CHKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] ch0_data = 8'h00;
    logic       ch0_valid = 1'b0;
    logic       ch0_ready;
    logic [7:0] ch1_data = 8'h00;
    logic       ch1_valid = 1'b0;
    logic       ch1_ready;
    logic       uart_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       grant_ch;
    logic       frame_done;
    logic       sched_busy;

    always #5 clk = ~clk;

    am_uart_sched #(
        .BURST_LEN(BL),
        .HDR0     (H0),
        .HDR1     (H1)
    ) dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .en        (en),
        .ch0_data  (ch0_data),
        .ch0_valid (ch0_valid),
        .ch0_ready (ch0_ready),
        .ch1_data  (ch1_data),
        .ch1_valid (ch1_valid),
        .ch1_ready (ch1_ready),
        .uart_busy (uart_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .grant_ch  (grant_ch),
        .frame_done(frame_done),
        .sched_busy(sched_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART: busy goes high the cycle after a strobe and stays high for 10 cycles.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy = (busy_cnt != 0);

    // Sources: each channel streams its queue; gate forces valid low.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit gate0 = 1'b1;
    bit gate1 = 1'b1;
    int acc0 = 0;
    int acc1 = 0;
    initial begin
        bit a0, a1;
        logic [7:0] dump;
        forever begin
            @(negedge clk);
            a0 = rst_n && ch0_valid && ch0_ready;
            a1 = rst_n && ch1_valid && ch1_ready;
            @(posedge clk);
            #1;
            if (a0 && q0.size() != 0) begin dump = q0.pop_front(); acc0++; end
            if (a1 && q1.size() != 0) begin dump = q1.pop_front(); acc1++; end
            ch0_valid = gate0 && (q0.size() != 0);
            ch0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
            ch1_valid = gate1 && (q1.size() != 0);
            ch1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
        end
    end

    // Monitor: records the transmitted stream and frame owners, checks per-cycle rules.
    logic [7:0] txq[$];
    bit         gq[$];
    int         done_cnt = 0;
    bit         pend = 1'b0;
    logic [7:0] pend_d = 8'h00;
    bit         prev_start = 1'b0;
    bit         prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_excl", 32'(ch0_ready & ch1_ready), 0);
            if (pend) begin
                check("acc_to_start", 32'(tx_start), 1);
                check("acc_to_data", 32'(tx_data), 32'(pend_d));
            end
            if (tx_start) begin
                check("start_vs_busy", 32'(uart_busy), 0);
                check("start_width", 32'(prev_start), 0);
                txq.push_back(tx_data);
            end
            if (frame_done) begin
                check("done_width", 32'(prev_done), 0);
                gq.push_back(grant_ch);
                done_cnt++;
            end
        end
        pend       = rst_n && ((ch0_valid && ch0_ready) || (ch1_valid && ch1_ready));
        pend_d     = ch1_ready ? ch1_data : ch0_data;
        prev_start = rst_n && tx_start;
        prev_done  = rst_n && frame_done;
    end

    // Expected-stream model.
    logic [7:0] src0[$];
    logic [7:0] src1[$];
    bit         expg[$];
    logic [7:0] expq[$];

    task automatic push_ch(input bit ch, input logic [7:0] d);
        if (ch) begin q1.push_back(d); src1.push_back(d); end
        else begin q0.push_back(d); src0.push_back(d); end
    endtask

    task automatic clear_model();
        src0.delete(); src1.delete(); expg.delete(); expq.delete();
        txq.delete(); gq.delete();
    endtask

    task automatic model_grants(input int n0, input int n1);
        int r0, r1;
        bit last, g;
        r0 = n0; r1 = n1; last = 1'b1;
        expg.delete();
        while (r0 + r1 > 0) begin
            if (r0 > 0 && r1 > 0) g = !last;
            else g = (r1 > 0);
            expg.push_back(g);
            if (g) r1--; else r0--;
            last = g;
        end
    endtask

    task automatic build_exp();
        int p0, p1;
        logic [7:0] x, b;
        p0 = 0; p1 = 0;
        expq.delete();
        foreach (expg[f]) begin
            expq.push_back(expg[f] ? H1 : H0);
            x = 8'h00;
            for (int k = 0; k < int'(BL); k++) begin
                if (expg[f]) begin b = src1[p1]; p1++; end
                else begin b = src0[p0]; p0++; end
                expq.push_back(b);
                x = x ^ b;
            end
            if (CSUM) expq.push_back(x);
        end
    endtask

    task automatic compare(input string tag);
        build_exp();
        check($sformatf("%s_stream_len", tag), txq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(txq[i]), 32'(expq[i]));
        check($sformatf("%s_frames", tag), gq.size(), expg.size());
        for (int i = 0; i < expg.size() && i < gq.size(); i++)
            check($sformatf("%s_grant%0d", tag, i), 32'(gq[i]), 32'(expg[i]));
    endtask

    task automatic check_reset_outs(input string tag);
        check($sformatf("%s_tx_data", tag), 32'(tx_data), 0);
        check($sformatf("%s_tx_start", tag), 32'(tx_start), 0);
        check($sformatf("%s_ch0_ready", tag), 32'(ch0_ready), 0);
        check($sformatf("%s_ch1_ready", tag), 32'(ch1_ready), 0);
        check($sformatf("%s_grant_ch", tag), 32'(grant_ch), 0);
        check($sformatf("%s_frame_done", tag), 32'(frame_done), 0);
        check($sformatf("%s_sched_busy", tag), 32'(sched_busy), 0);
    endtask

    // Entered and left just after a rising edge.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0; en = 1'b0; gate0 = 1'b1; gate1 = 1'b1;
        q0.delete(); q1.delete();
        repeat (cycles) @(posedge clk);
        #1;
        clear_model();
        done_cnt = 0; acc0 = 0; acc1 = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n);
        int c;
        c = 0;
        while (done_cnt < n && c < 3000) begin @(posedge clk); #1; c++; end
        check("wait_frame_done", 32'(done_cnt >= n), 1);
    endtask

    task automatic wait_acc0(input int n);
        int c;
        c = 0;
        while (acc0 < n && c < 3000) begin @(posedge clk); #1; c++; end
        check("wait_ch0_accept", 32'(acc0 >= n), 1);
    endtask

    task automatic settle(input int nfr);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("settle_idle", 32'(sched_busy), 0);
        check("settle_frames", done_cnt, nfr);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         n0;
        int         n1;
        logic [7:0] b0;
        logic [7:0] b1;
        int         nfr;
        logic [7:0] gmask;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] cs_bytes[2][4];
    logic [7:0] cs_exp[2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // n0/n1 frames of data queued from reset; gmask bit f = owner of frame f.
        vecs[0] = '{n0: 1, n1: 0, b0: 8'h01, b1: 8'h00, nfr: 1, gmask: 8'h00};
        vecs[1] = '{n0: 2, n1: 2, b0: 8'h10, b1: 8'h80, nfr: 4, gmask: 8'h0A};
        vecs[2] = '{n0: 3, n1: 1, b0: 8'h20, b1: 8'hC0, nfr: 4, gmask: 8'h02};
        vecs[3] = '{n0: 0, n1: 2, b0: 8'h00, b1: 8'h40, nfr: 2, gmask: 8'h03};
        vecs[4] = '{n0: 1, n1: 3, b0: 8'hF0, b1: 8'h60, nfr: 4, gmask: 8'h0E};
        cs_bytes[0] = '{8'h0F, 8'hF0, 8'h33, 8'hCC};
        cs_bytes[1] = '{8'h01, 8'h02, 8'h04, 8'h08};
        cs_exp[0]   = 8'h00;
        cs_exp[1]   = 8'h0F;

        for (int v = 0; v < 5; v++) begin
            do_reset(12);
            for (int k = 0; k < vecs[v].n0 * int'(BL); k++) push_ch(1'b0, vecs[v].b0 + k[7:0]);
            for (int k = 0; k < vecs[v].n1 * int'(BL); k++) push_ch(1'b1, vecs[v].b1 + k[7:0]);
            for (int f = 0; f < vecs[v].nfr; f++) expg.push_back(vecs[v].gmask[f]);
            en = 1'b1;
            wait_done(vecs[v].nfr);
            settle(vecs[v].nfr);
            compare($sformatf("vec%0d", v));
        end

        // Header strobe one cycle after valid is seen in idle.
        do_reset(12);
        en = 1'b1;
        push_ch(1'b0, 8'hDE); push_ch(1'b0, 8'hAD); push_ch(1'b0, 8'hBE); push_ch(1'b0, 8'hEF);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ch0_valid) break;
        end
        check("lat_idle_busy", 32'(sched_busy), 0);
        @(negedge clk);
        check("lat_hdr_start", 32'(tx_start), 1);
        check("lat_hdr_data", 32'(tx_data), 32'(H0));
        check("lat_hdr_grant", 32'(grant_ch), 0);
        check("lat_hdr_busy", 32'(sched_busy), 1);
        @(posedge clk);
        #1;
        expg.push_back(1'b0);
        wait_done(1);
        settle(1);
        compare("lat");

        // ch0 stalls after its second byte while ch1 keeps offering data.
        do_reset(12);
        en = 1'b1;
        push_ch(1'b0, 8'h11); push_ch(1'b0, 8'h22); push_ch(1'b0, 8'h33); push_ch(1'b0, 8'h44);
        push_ch(1'b1, 8'hA1); push_ch(1'b1, 8'hA2); push_ch(1'b1, 8'hA3); push_ch(1'b1, 8'hA4);
        expg.push_back(1'b0); expg.push_back(1'b1);
        wait_acc0(2);
        gate0 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall_ch1_ready", 32'(ch1_ready), 0);
            check("stall_busy", 32'(sched_busy), 1);
        end
        @(posedge clk);
        #1;
        check("stall_acc0", acc0, 2);
        gate0 = 1'b1;
        wait_done(2);
        settle(2);
        compare("stall");

        // en dropped mid-frame: frame finishes, nothing new starts until en returns.
        do_reset(12);
        en = 1'b1;
        for (int k = 0; k < 4; k++) push_ch(1'b0, 8'h30 + 8'(k));
        for (int k = 0; k < 4; k++) push_ch(1'b1, 8'hB0 + 8'(k));
        expg.push_back(1'b0); expg.push_back(1'b1);
        wait_acc0(1);
        en = 1'b0;
        wait_done(1);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("en_low_start", 32'(tx_start), 0);
            check("en_low_busy", 32'(sched_busy), 0);
        end
        @(posedge clk);
        #1;
        check("en_low_frames", done_cnt, 1);
        en = 1'b1;
        wait_done(2);
        settle(2);
        compare("en_low");

        // One-cycle reset during the third data byte abandons the frame.
        do_reset(12);
        en = 1'b1;
        push_ch(1'b0, 8'h55); push_ch(1'b0, 8'h66); push_ch(1'b0, 8'h77); push_ch(1'b0, 8'h88);
        wait_acc0(3);
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("midrst");
        @(posedge clk);
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", 32'(sched_busy), 0);
        // The short reset must also restore the tie-break in favour of ch0.
        clear_model();
        for (int k = 0; k < 4; k++) push_ch(1'b0, 8'h70 + 8'(k));
        for (int k = 0; k < 4; k++) push_ch(1'b1, 8'hE0 + 8'(k));
        expg.push_back(1'b0); expg.push_back(1'b1);
        wait_done(2);
        settle(2);
        compare("post_rst");

        // Checksum frames.
        for (int s = 0; s < 2; s++) begin
            do_reset(12);
            en = 1'b1;
            for (int k = 0; k < 4; k++) push_ch(1'b0, cs_bytes[s][k]);
            expg.push_back(1'b0);
            wait_done(1);
            settle(1);
            compare($sformatf("csum%0d", s));
`ifdef SCHED_CHKSUM_EN
            check("csum_sixth_byte", (txq.size() > 5) ? 32'(txq[5]) : 32'hFFFF_FFFF,
                  32'(cs_exp[s]));
`else
            check("plain_frame_len", txq.size(), 5);
`endif
        end

        // Randomized traffic with en toggling.
        for (int it = 0; it < 3; it++) begin
            int n0, n1, c;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            do_reset(12);
            for (int k = 0; k < n0 * int'(BL); k++) push_ch(1'b0, 8'($urandom));
            for (int k = 0; k < n1 * int'(BL); k++) push_ch(1'b1, 8'($urandom));
            model_grants(n0, n1);
            c = 0;
            while (done_cnt < expg.size() && c < 6000) begin
                en = ($urandom_range(0, 9) < 7);
                @(posedge clk);
                #1;
                c++;
            end
            en = 1'b1;
            wait_done(expg.size());
            settle(expg.size());
            compare($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am_uart_sched.md
AM_UART_SCHED -- requirements
Module: am_uart_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, data bytes per frame; legal range 1..255.
REQ-002 SHALL have parameter HDR0, default 8'hA5, header byte for channel 0 frames.
REQ-003 SHALL have parameter HDR1, default 8'h5A, header byte for channel 1 frames.
REQ-004 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  permits new frames to start.
REQ-007 SHALL have port ch0_data  input  8  AD9226 sample byte.
REQ-008 SHALL have port ch0_valid  input  1  ch0_data valid.
REQ-009 SHALL have port ch0_ready  output  1  channel 0 byte accepted when high with ch0_valid.
REQ-010 SHALL have ports ch1_data/ch1_valid/ch1_ready with the same widths and meaning for the AD9481 sample stream.
REQ-011 SHALL have port uart_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port tx_data  output  8  byte to the UART, registered.
REQ-013 SHALL have port tx_start  output  1  one-cycle transmit strobe.
REQ-014 SHALL have port grant_ch  output  1  channel owning the current or most recent frame.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-016 SHALL have port sched_busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement states IDLE, HDR, FETCH, SEND, CSUM, GUARD, WAITB, DONE.
REQ-018 IDLE SHALL go to HDR when en=1 and either valid is high; if both are valid, it SHALL grant !last_ch, otherwise the valid channel; grant_ch SHALL update on the same edge.
REQ-019 en=0 SHALL only block leaving IDLE; a frame in progress SHALL complete.
REQ-020 HDR SHALL drive tx_data=HDR0 or HDR1 (per grant_ch) and tx_start=1 for exactly one cycle, then go to GUARD.
REQ-021 GUARD SHALL last one cycle with uart_busy ignored, then go to WAITB.
REQ-022 WAITB SHALL hold while uart_busy=1; when uart_busy=0:
  - to FETCH if byte_cnt<BURST_LEN;
  - otherwise to CSUM when checksum is enabled and not yet sent;
  - otherwise to DONE.
REQ-023 FETCH SHALL assert ready combinationally for the granted channel only; the other ready SHALL be 0.
REQ-024 In FETCH, the byte SHALL be captured into tx_data and the state SHALL go to SEND on the edge where granted valid&ready=1; FETCH SHALL wait indefinitely otherwise.
REQ-025 SEND SHALL assert tx_start for one cycle, increment byte_cnt, then go to GUARD.
REQ-026 tx_data SHALL stay stable from each start strobe until the next load.
REQ-027 Valid from the non-granted channel SHALL be ignored for the whole frame.
REQ-028 DONE SHALL pulse frame_done for one cycle, set last_ch=grant_ch, clear byte_cnt, and go to IDLE.
REQ-029 Latency SHALL be: valid pair in IDLE to first tx_start (header) = 1 cycle; data accept to its tx_start = 1 cycle.
REQ-030 tx_start SHALL never assert while uart_busy=1 outside GUARD.

Reset
REQ-031 RST_n=0 SHALL reset, at the next edge:
  - state=IDLE, byte_cnt=0, last_ch=1 so ch0 wins the first tie;
  - tx_data=0, tx_start=0, ch0_ready=0, ch1_ready=0;
  - grant_ch=0, frame_done=0, sched_busy=0, checksum=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done pulse.

Configuration
REQ-033 Macro SCHED_CHKSUM_EN defined SHALL:
  - keep a running XOR of the frame's data bytes, cleared at HDR;
  - in CSUM, load that XOR into tx_data and strobe tx_start, then go to GUARD/WAITB, then DONE.
REQ-034 Macro SCHED_CHKSUM_EN undefined SHALL remove the CSUM state and XOR register; a frame SHALL be header plus BURST_LEN bytes.

Verification (BURST_LEN=4; UART model raises busy one cycle after tx_start for 10 cycles)
REQ-035 Bench SHALL cover: only ch0 valid, bytes 01,02,03,04 -> tx sequence A5,01,02,03,04; frame_done once; grant_ch=0.
REQ-036 Bench SHALL cover: both valid from reset -> ch0 frame, then ch1 frame (5A...), then ch0; strict alternation.
REQ-037 Bench SHALL cover: ch0 valid drops for 20 cycles after second byte -> FETCH holds, ch1_ready stays 0, frame resumes intact.
REQ-038 Bench SHALL cover: en=0 during a frame -> frame completes; no new HDR until en=1.
REQ-039 Bench SHALL cover: RST_n low for 1 cycle during third data byte -> all outputs at reset values next cycle; no frame_done.
REQ-040 Bench SHALL cover, with SCHED_CHKSUM_EN: bytes 0F,F0,33,CC -> sixth byte 00; bytes 01,02,04,08 -> sixth byte 0F.
